program_memory_loader: RTL

- Instruction memory for the 4-bit CPU: 64 bytes, indexed by the CPU's 6-bit address (mode[1:0], addr[3:0]).
- Fetch side is a combinational read, so an instruction is available in the same cycle as the fetch address.
- Load side is a byte-stream receiver with valid/ready handshake that writes new programs into memory.
- Controls the CPU's active-low reset: the CPU is held in reset while a program loads and is released only after a valid checksum.

---
 rtl/program_memory_loader_if.sv | 19 +
 rtl/program_memory_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/program_memory_loader_if.sv
// Byte-stream load channel for the program memory loader.
// Master drives bytes with ld_valid; slave accepts with ld_ready.
interface program_memory_loader_if;
    logic       ld_valid;
    logic [7:0] ld_byte;
    logic       ld_ready;

    modport master (
        output ld_valid,
        output ld_byte,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_byte,
        output ld_ready
    );
endinterface

// File: rtl/program_memory_loader.sv
// 64-byte instruction store for the 4-bit CPU with a framed byte loader
// that owns the CPU's active-low reset.
module program_memory_loader #(
    parameter int         DEPTH          = 64,
    parameter bit         BOOT_HOLD      = 1'b1,
    parameter int         RELEASE_CYCLES = 2,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] addr,
    output logic [7:0] data,
    program_memory_loader_if.slave ld,
    output logic       cpu_reset,
    output logic       busy,
    output logic       err,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_REL
    } state_t;

    localparam logic [3:0] LP_REL   = 4'(RELEASE_CYCLES - 1);
    localparam logic [7:0] LP_DEPTH = 8'(DEPTH);

    state_t     r_state;
    logic [6:0] r_cnt;
    logic [6:0] r_len;
    logic [7:0] r_sum;
    logic [3:0] r_rel;
    logic       r_cpu_rst;
    logic       r_err;
    logic       r_done;
    logic       r_boot;
    logic [7:0] r_mem [DEPTH];

    logic       w_acc;
    logic       w_wr;
    logic       w_sync;
    logic [7:0] w_sum;

    assign w_acc  = ld.ld_valid && ld.ld_ready;
    assign w_wr   = w_acc && (r_state == S_DATA);
    assign w_sync = w_acc && (ld.ld_byte == SYNC_BYTE);
    assign w_sum  = r_sum + ld.ld_byte;

    assign ld.ld_ready = (r_state != S_REL);
    assign busy        = (r_state != S_IDLE);
    assign cpu_reset   = r_cpu_rst;
    assign err         = r_err;
    assign done        = r_done;
    assign data        = r_mem[addr];

    // Program store survives reset; only the loader writes it.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_cnt[5:0]] <= ld.ld_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_sum     <= '0;
            r_rel     <= '0;
            r_cpu_rst <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_boot    <= !BOOT_HOLD;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // A sync byte outranks the pending boot release.
                    if (w_sync) begin
                        r_state   <= S_LEN;
                        r_err     <= 1'b0;
                        r_sum     <= '0;
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b0;
                        r_boot    <= 1'b0;
                    end else if (r_boot) begin
                        r_state <= S_REL;
                        r_rel   <= LP_REL;
                        r_boot  <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_acc) begin
                        if (ld.ld_byte == 8'd0 || ld.ld_byte > LP_DEPTH) begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_len   <= ld.ld_byte[6:0];
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_sum <= w_sum;
                        r_cnt <= r_cnt + 7'd1;
                        if (r_cnt == r_len - 7'd1) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_acc) begin
                        if (w_sum == 8'd0) begin
                            r_state <= S_REL;
                            r_rel   <= LP_REL;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_REL: begin
                    if (r_rel == 4'd0) begin
                        r_state   <= S_IDLE;
                        r_cpu_rst <= 1'b1;
                    end else begin
                        r_rel <= r_rel - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
